// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data pipeline stages
// Ports: clk/rst clock and synchronous active-high reset;
//   if_req/if_addr fetch request; d_req/d_we/d_addr/d_wdata data request;
//   mem_ack/mem_rdata memory completion; mem_req/mem_we/mem_addr/mem_wdata registered memory command;
//   if_ack/d_ack one-cycle completion pulses; if_rdata/d_rdata returned read data;
//   if_stall/d_stall combinational pipeline holds.
// Define ARB_FAIR_EN to add a starvation counter that lets fetch win a tie after three data grants.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_ack,
  output logic        d_ack,
  output logic [31:0] if_rdata,
  output logic [31:0] d_rdata,
  output logic        if_stall,
  output logic        d_stall
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        d_win;
`ifdef ARB_FAIR_EN
  logic [1:0]  starve_q, starve_d;
  // a starved fetch beats a pending data request
  assign d_win = d_req & ~(if_req & (starve_q == 2'd3));
`else
  assign d_win = d_req;
`endif
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
`ifdef ARB_FAIR_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
`ifdef ARB_FAIR_EN
          if (if_req && starve_q != 2'd3) starve_d = starve_q + 2'd1;
`endif
        end else if (if_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
`ifdef ARB_FAIR_EN
          starve_d    = 2'd0;
`endif
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = mem_we_q ? d_rdata_q : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
`ifdef ARB_FAIR_EN
      starve_q    <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_FAIR_EN
      starve_q    <= starve_d;
`endif
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst, if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        mem_req, mem_we, if_ack, d_ack, if_stall, d_stall;
  logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;
  int          errors = 0, checks = 0, starve = 0;
  logic [31:0] if_rd_m = 32'h0, d_rd_m = 32'h0;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_ack(if_ack), .d_ack(d_ack), .if_rdata(if_rdata), .d_rdata(d_rdata),
    .if_stall(if_stall), .d_stall(d_stall)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  // Serves one transaction starting with the arbiter idle and requests already presented.
  task automatic txn(input int lat, input logic [31:0] rd, input logic keep_i, input logic keep_d, input logic drop_ok);
    logic        win_d, ew;
    logic [31:0] ea, ewd;
    win_d = d_req && !(FAIR && if_req && starve == 3);
    ea    = win_d ? d_addr : if_addr;
    ew    = win_d & d_we;
    ewd   = win_d ? d_wdata : 32'h0;
    starve = win_d ? ((if_req && starve < 3) ? starve + 1 : starve) : 0;
    tick();
    chk1("grant_req", mem_req, 1'b1);
    chk("grant_addr", mem_addr, ea);
    chk1("grant_we", mem_we, ew);
    chk("grant_wdata", mem_wdata, ewd);
    mem_ack = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (drop_ok && $urandom_range(0, 3) == 0) begin
        if (win_d) d_req = 1'b0;
        else if_req = 1'b0;
      end
      tick();
      chk1("busy_req", mem_req, 1'b1);
      chk("busy_addr", mem_addr, ea);
      chk("busy_wdata", mem_wdata, ewd);
      chk1("busy_ack", if_ack | d_ack, 1'b0);
      chk1("busy_stall", win_d ? d_stall : if_stall, win_d ? d_req : if_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
    if (win_d && !ew) d_rd_m = rd;
    if (!win_d) if_rd_m = rd;
    chk1("done_req", mem_req, 1'b0);
    chk1("if_ack", if_ack, !win_d);
    chk1("d_ack", d_ack, win_d);
    chk("if_rdata", if_rdata, if_rd_m);
    chk("d_rdata", d_rdata, d_rd_m);
    chk1("ack_stall", win_d ? d_stall : if_stall, 1'b0);
    if (win_d) begin
      d_req   = keep_d;
      d_we    = 1'($urandom);
      d_addr  = {1'b1, 31'($urandom)};
      d_wdata = $urandom;
    end else begin
      if_req  = keep_i;
      if_addr = {1'b0, 31'($urandom)};
    end
    tick();
    chk1("idle_acks", if_ack | d_ack, 1'b0);
    chk1("idle_req", mem_req, 1'b0);
  endtask
  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_acks", if_ack | d_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h4;
    txn(2, 32'h8C220000, 1'b0, 1'b0, 1'b0);
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    txn(1, $urandom, 1'b0, 1'b0, 1'b0);
    txn(0, $urandom, 1'b0, 1'b0, 1'b0);
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80000200;
    repeat (4) txn(1, $urandom, 1'b1, 1'b1, 1'b0);
    txn(0, $urandom, 1'b0, 1'b0, 1'b0);
    txn(0, $urandom, 1'b0, 1'b0, 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80000020;
    tick();
    chk1("rstmid_busy", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    starve = 0; if_rd_m = 32'h0; d_rd_m = 32'h0;
    tick();
    mem_ack = 1'b0;
    chk1("rstmid_d_ack", d_ack, 1'b0);
    chk1("rstmid_if_ack", if_ack, 1'b0);
    chk1("rstmid_req", mem_req, 1'b0);
    chk1("rstmid_we", mem_we, 1'b0);
    chk("rstmid_addr", mem_addr, 32'h0);
    chk("rstmid_wdata", mem_wdata, 32'h0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    chk("rstmid_if_rdata", if_rdata, 32'h0);
    tick();
    chk1("rstmid_idle", mem_req, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80000040;
    tick();
    chk1("tied_grant", mem_req, 1'b1);
    chk1("tied_noack", d_ack, 1'b0);
    tick();
    d_rd_m = 32'h55;
    chk1("tied_ack", d_ack, 1'b1);
    chk("tied_rdata", d_rdata, d_rd_m);
    chk1("tied_req_low", mem_req, 1'b0);
    d_req = 1'b0;
    tick();
    chk1("tied_one_ack_a", d_ack, 1'b0);
    tick();
    chk1("tied_one_ack_b", d_ack, 1'b0);
    chk1("tied_idle", mem_req, 1'b0);
    mem_ack = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if_req  = 1'($urandom);
      d_req   = 1'($urandom);
      if (!if_req && !d_req) d_req = 1'b1;
      d_we    = 1'($urandom);
      if_addr = {1'b0, 31'($urandom)};
      d_addr  = {1'b1, 31'($urandom)};
      d_wdata = $urandom;
      txn($urandom_range(0, 3), $urandom, 1'($urandom), 1'($urandom), 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
